nand2_bist: RTL and testbench

- Built-in self-test sequencer for the 2-input NAND cell of the 7-track 5V library, used on the cell characterization test chip.
- Upstream side: drives the cell's A1/A2 inputs with an exhaustive vector sequence.
- Downstream side: samples the cell's ZN output after a programmable settle time and checks it against the golden NAND function.
- Reports error count, first failing vector and a pass flag to the test-chip register bank.

---
 rtl/nand2_bist_pkg.sv | 24 ++
 rtl/nand2_bist_checker.sv | 42 ++++
 rtl/nand2_bist.sv | 142 ++++++++++++++
 tb/tb_nand2_bist.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand2_bist_pkg.sv
// Shared definitions for the 2-input cell BIST sequencer: state encoding,
// vector geometry and the golden response of the cell under test.
package nand2_bist_pkg;

  localparam int VEC_W    = 2;
  localparam int SETTLE_W = 4;
  localparam int PASS_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [VEC_W-1:0] VEC_FIRST = '0;
  localparam logic [VEC_W-1:0] VEC_LAST  = '1;
  localparam logic [VEC_W-1:0] VEC_QUIET = '1;

  // Swap this body for nor2/and2 variants; the sequencer stays unchanged.
  function automatic logic golden_zn(input logic [VEC_W-1:0] vec);
    return ~(vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/nand2_bist_checker.sv
// Compares the sampled cell output against the golden response and keeps
// the saturating mismatch count plus the first failing vector.
module nand2_bist_checker
  import nand2_bist_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             sample,
  input  logic [VEC_W-1:0] vec,
  input  logic             zn,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_fail
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic mismatch;

  assign mismatch = sample && (zn != golden_zn(vec));

  // A zero count marks the first mismatch; saturation never returns to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (clr) begin
      err_cnt    <= '0;
      first_fail <= '0;
    end else if (mismatch) begin
      if (err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
      if (err_cnt == '0) begin
        first_fail <= vec;
      end
    end
  end

endmodule

// File: rtl/nand2_bist.sv
// Exhaustive-vector BIST sequencer for the NAND2 cell on the test chip.
//
// state | meaning
// IDLE  | quiescent, A1=A2=1, waiting for START
// HOLD  | driving a vector and counting down its settle time
// DONE  | run complete, results held for the register bank
module nand2_bist
  import nand2_bist_pkg::*;
#(
  parameter int NUM_PASSES = 4,
  parameter int SETTLE     = 1,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ZN,
  output logic             A1,
  output logic             A2,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [1:0]       FIRST_FAIL
);

  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);
  localparam logic [PASS_W-1:0]   PASS_LD   = PASS_W'(NUM_PASSES - 1);

  logic                rst_sync;
  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [VEC_W-1:0]    drv_q, drv_d;
  logic                sample;
  logic                run_start;

  // Reset asserts immediately but releases on a clock edge, so a START
  // coinciding with the release edge is not accepted.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rst_sync <= 1'b1;
    end else begin
      rst_sync <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge rst_sync) begin
    if (rst_sync) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      pass_q   <= '0;
      vec_q    <= '0;
      drv_q    <= VEC_QUIET;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
      vec_q    <= vec_d;
      drv_q    <= drv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    pass_d    = pass_q;
    vec_d     = vec_q;
    drv_d     = drv_q;
    sample    = 1'b0;
    run_start = 1'b0;

    if (ABORT) begin
      state_d  = ST_IDLE;
      settle_d = '0;
      pass_d   = '0;
      vec_d    = '0;
      drv_d    = VEC_QUIET;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            run_start = 1'b1;
            state_d   = ST_HOLD;
            settle_d  = SETTLE_LD;
            pass_d    = PASS_LD;
            vec_d     = VEC_FIRST;
            drv_d     = VEC_FIRST;
          end
        end
        ST_HOLD: begin
          if (settle_q != '0) begin
            settle_d = settle_q - SETTLE_W'(1);
          end else begin
            // Terminal count: sample this vector and move on in the same edge.
            sample   = 1'b1;
            settle_d = SETTLE_LD;
            if (vec_q == VEC_LAST) begin
              vec_d = VEC_FIRST;
              if (pass_q == '0) begin
                state_d = ST_DONE;
                drv_d   = VEC_QUIET;
              end else begin
                pass_d = pass_q - PASS_W'(1);
                drv_d  = VEC_FIRST;
              end
            end else begin
              vec_d = vec_q + VEC_W'(1);
              drv_d = vec_q + VEC_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          drv_d   = VEC_QUIET;
        end
      endcase
    end
  end

  nand2_bist_checker #(
    .ERR_W(ERR_W)
  ) u_checker (
    .CLK       (CLK),
    .RST       (rst_sync),
    .clr       (run_start),
    .sample    (sample),
    .vec       (drv_q),
    .zn        (ZN),
    .err_cnt   (ERR_CNT),
    .first_fail(FIRST_FAIL)
  );

  assign A1   = drv_q[1];
  assign A2   = drv_q[0];
  assign BUSY = (state_q == ST_HOLD);
  assign DONE = (state_q == ST_DONE);
  assign PASS = DONE && (ERR_CNT == '0);

endmodule

// File: tb/tb_nand2_bist.sv
// Directed bench for nand2_bist: three instances (defaults, ERR_W=3,
// SETTLE=3) share stimulus; each gets its own cell model on ZN.
module tb_nand2_bist;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       ABORT;
  logic [1:0] zn_mode;

  int n_checks = 0;
  int n_errors = 0;

  logic       a1_d, a2_d, busy_d, done_d, pass_d, zn_d, d1_d, d2_d;
  logic [7:0] err_d;
  logic [1:0] ff_d;
  logic       a1_w, a2_w, busy_w, done_w, pass_w, zn_w, d1_w, d2_w;
  logic [2:0] err_w;
  logic [1:0] ff_w;
  logic       a1_s, a2_s, busy_s, done_s, pass_s, zn_s, d1_s, d2_s;
  logic [7:0] err_s;
  logic [1:0] ff_s;

  always #5 CLK = ~CLK;

  // mode 0 ideal NAND, 1 stuck-at-0, 2 stuck-at-1, 3 two-register delayed NAND
  function automatic logic zn_model(input logic [1:0] mode, input logic a1, input logic a2,
                                    input logic dly);
    case (mode)
      2'd0:    return ~(a1 & a2);
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return dly;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    d1_d <= ~(a1_d & a2_d);
    d2_d <= d1_d;
    d1_w <= ~(a1_w & a2_w);
    d2_w <= d1_w;
    d1_s <= ~(a1_s & a2_s);
    d2_s <= d1_s;
  end

  assign zn_d = zn_model(zn_mode, a1_d, a2_d, d2_d);
  assign zn_w = zn_model(zn_mode, a1_w, a2_w, d2_w);
  assign zn_s = zn_model(zn_mode, a1_s, a2_s, d2_s);

  nand2_bist dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ZN(zn_d),
    .A1(a1_d), .A2(a2_d), .BUSY(busy_d), .DONE(done_d), .PASS(pass_d),
    .ERR_CNT(err_d), .FIRST_FAIL(ff_d)
  );

  nand2_bist #(.ERR_W(3)) dut_w3 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ZN(zn_w),
    .A1(a1_w), .A2(a2_w), .BUSY(busy_w), .DONE(done_w), .PASS(pass_w),
    .ERR_CNT(err_w), .FIRST_FAIL(ff_w)
  );

  nand2_bist #(.SETTLE(3)) dut_s3 (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ZN(zn_s),
    .A1(a1_s), .A2(a2_s), .BUSY(busy_s), .DONE(done_s), .PASS(pass_s),
    .ERR_CNT(err_s), .FIRST_FAIL(ff_s)
  );

  // Abort all instances, start a run, and record cycles from the START edge
  // to DONE for each instance; -1 means DONE never arrived.
  task automatic run_sweep(input int poke_at, output int c_d, output int c_w, output int c_s);
    int k;
    logic [1:0] exp_v;
    c_d = -1;
    c_w = -1;
    c_s = -1;
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    k = 0;
    while ((c_d < 0 || c_w < 0 || c_s < 0) && k < 200) begin
      if (c_d < 0) begin
        if (done_d) begin
          c_d = k;
        end else begin
          exp_v = 2'((k / 2) % 4);
          n_checks++;
          if (busy_d !== 1'b1 || {a1_d, a2_d} !== exp_v) begin
            n_errors++;
            $display("FAIL run_vector k=%0d: busy=%b vec=%b, expected busy=1 vec=%b",
                     k, busy_d, {a1_d, a2_d}, exp_v);
          end
        end
      end
      if (c_w < 0 && done_w) c_w = k;
      if (c_s < 0 && done_s) c_s = k;
      START = (k == poke_at);
      @(negedge CLK);
      k++;
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({a1_d, a2_d, busy_d, done_d, pass_d} !== 5'b11000) begin
      n_errors++;
      $display("FAIL reset_ctrl: {A1,A2,BUSY,DONE,PASS}=%b, expected 11000",
               {a1_d, a2_d, busy_d, done_d, pass_d});
    end
    n_checks++;
    if (err_d !== 8'd0 || ff_d !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_err: err=%0d ff=%b, expected 0 00", err_d, ff_d);
    end
  endtask

  task automatic test_ideal();
    int c_d, c_w, c_s;
    zn_mode = 2'd0;
    run_sweep(5, c_d, c_w, c_s);
    n_checks++;
    if (c_d !== 32) begin
      n_errors++;
      $display("FAIL ideal_len: %0d cycles, expected 32", c_d);
    end
    n_checks++;
    if (done_d !== 1'b1 || pass_d !== 1'b1 || err_d !== 8'd0) begin
      n_errors++;
      $display("FAIL ideal_result: done=%b pass=%b err=%0d, expected 1 1 0", done_d, pass_d, err_d);
    end
    n_checks++;
    if ({a1_d, a2_d, busy_d} !== 3'b110) begin
      n_errors++;
      $display("FAIL ideal_quiet: {A1,A2,BUSY}=%b, expected 110", {a1_d, a2_d, busy_d});
    end
    n_checks++;
    if (c_s !== 64 || pass_s !== 1'b1) begin
      n_errors++;
      $display("FAIL ideal_settle3: %0d cycles pass=%b, expected 64 1", c_s, pass_s);
    end
  endtask

  task automatic test_stuck0();
    int c_d, c_w, c_s;
    zn_mode = 2'd1;
    run_sweep(-1, c_d, c_w, c_s);
    n_checks++;
    if (err_d !== 8'd12 || ff_d !== 2'b00 || pass_d !== 1'b0 || done_d !== 1'b1) begin
      n_errors++;
      $display("FAIL stuck0: err=%0d ff=%b pass=%b done=%b, expected 12 00 0 1",
               err_d, ff_d, pass_d, done_d);
    end
    n_checks++;
    if (err_w !== 3'd7 || c_w !== 32 || pass_w !== 1'b0) begin
      n_errors++;
      $display("FAIL stuck0_sat: err=%0d len=%0d pass=%b, expected 7 32 0", err_w, c_w, pass_w);
    end
  endtask

  task automatic test_stuck1();
    int c_d, c_w, c_s;
    zn_mode = 2'd2;
    run_sweep(-1, c_d, c_w, c_s);
    n_checks++;
    if (err_d !== 8'd4 || ff_d !== 2'b11 || pass_d !== 1'b0 || c_d !== 32) begin
      n_errors++;
      $display("FAIL stuck1: err=%0d ff=%b pass=%b len=%0d, expected 4 11 0 32",
               err_d, ff_d, pass_d, c_d);
    end
  endtask

  task automatic test_abort();
    int c_d, c_w, c_s;
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    zn_mode = 2'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (10) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    n_checks++;
    if ({busy_d, done_d, a1_d, a2_d} !== 4'b0011) begin
      n_errors++;
      $display("FAIL abort_ctrl: {BUSY,DONE,A1,A2}=%b, expected 0011", {busy_d, done_d, a1_d, a2_d});
    end
    // samples of 00,01,10,11,00 before the abort edge; three plus one miss
    n_checks++;
    if (err_d !== 8'd4 || ff_d !== 2'b00) begin
      n_errors++;
      $display("FAIL abort_hold: err=%0d ff=%b, expected 4 00", err_d, ff_d);
    end
    ABORT = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    START = 1'b0;
    n_checks++;
    if (busy_d !== 1'b0 || err_d !== 8'd4) begin
      n_errors++;
      $display("FAIL abort_wins: busy=%b err=%0d, expected 0 4", busy_d, err_d);
    end
    zn_mode = 2'd0;
    run_sweep(-1, c_d, c_w, c_s);
    n_checks++;
    if (c_d !== 32 || pass_d !== 1'b1 || err_d !== 8'd0) begin
      n_errors++;
      $display("FAIL abort_rerun: len=%0d pass=%b err=%0d, expected 32 1 0", c_d, pass_d, err_d);
    end
  endtask

  task automatic test_delay();
    int c_d, c_w, c_s;
    zn_mode = 2'd3;
    run_sweep(-1, c_d, c_w, c_s);
    n_checks++;
    if (err_d === 8'd0 || pass_d !== 1'b0 || done_d !== 1'b1) begin
      n_errors++;
      $display("FAIL delay_settle1: err=%0d pass=%b done=%b, expected err>0 0 1", err_d, pass_d, done_d);
    end
    n_checks++;
    if (err_s !== 8'd0 || pass_s !== 1'b1 || c_s !== 64) begin
      n_errors++;
      $display("FAIL delay_settle3: err=%0d pass=%b len=%0d, expected 0 1 64", err_s, pass_s, c_s);
    end
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    zn_mode = 2'd1;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    n_checks++;
    if (err_d !== 8'd2 || busy_d !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pre: err=%0d busy=%b, expected 2 1", err_d, busy_d);
    end
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({a1_d, a2_d, busy_d, done_d, pass_d} !== 5'b11000 || err_d !== 8'd0 || ff_d !== 2'b00) begin
      n_errors++;
      $display("FAIL rst_async: {A1,A2,BUSY,DONE,PASS}=%b err=%0d ff=%b, expected 11000 0 00",
               {a1_d, a2_d, busy_d, done_d, pass_d}, err_d, ff_d);
    end
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (busy_d !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_release_start: busy=%b, expected 0", busy_d);
    end
    START = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (busy_d !== 1'b0 || done_d !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_after: busy=%b done=%b, expected 0 0", busy_d, done_d);
    end
  endtask

  initial begin
    RST     = 1'b1;
    START   = 1'b0;
    ABORT   = 1'b0;
    zn_mode = 2'd0;
    repeat (3) @(negedge CLK);
    test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    test_ideal();
    test_stuck0();
    test_stuck1();
    test_abort();
    test_delay();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
